alarm_ack_ctrl: RTL and testbench



---
 rtl/alarm_pkg.sv | 28 ++
 rtl/alarm_ack_ctrl_btn_debounce.sv | 58 +++++
 rtl/alarm_ack_ctrl.sv | 167 ++++++++++++++++
 tb/tb_alarm_ack_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types, defaults and width helpers for the alarm acknowledge block.
package alarm_pkg;

  // FSM state encoding.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Default timing for the 100 MHz board clock.
  localparam int unsigned DEF_CLK_HZ           = 100000000;
  localparam int unsigned DEF_DEBOUNCE_CYCLES  = 1000000;
  localparam int unsigned DEF_SNOOZE_SEC       = 5;
  localparam int unsigned DEF_MAX_SNOOZES      = 3;
  localparam int unsigned DEF_RING_TIMEOUT_SEC = 30;

  // Bits needed for a counter that runs 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DEF_TICK_W = cnt_width(DEF_CLK_HZ);
  localparam int unsigned DEF_DEB_W  = cnt_width(DEF_DEBOUNCE_CYCLES);
  localparam int unsigned DEF_SEC_W  = cnt_width(DEF_RING_TIMEOUT_SEC + 1);

endpackage

// File: rtl/alarm_ack_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter, accepted level
// and a one-cycle pulse on every accepted press.
module btn_debounce
  import alarm_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Accept the synced level once it has differed from the accepted one
  // for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      level_d = sync2_q;
      press_d = sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Synchroniser and debounce state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/alarm_ack_ctrl.sv
// Alarm acknowledge controller: turns the timer's alarm request into a ring
// output, with dismiss (enter), snooze (down) and a ring timeout.
module alarm_ack_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned CLK_HZ           = DEF_CLK_HZ,
  parameter int unsigned DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned SNOOZE_SEC       = DEF_SNOOZE_SEC,
  parameter int unsigned MAX_SNOOZES      = DEF_MAX_SNOOZES,
  parameter int unsigned RING_TIMEOUT_SEC = DEF_RING_TIMEOUT_SEC
) (
  input  logic       clk_100mhz,
  input  logic       rst_n,
  input  logic       en,
  input  logic       alarm_req,
  input  logic       btn_enter,
  input  logic       btn_down,
  output logic       ring,
  output logic       snoozing,
  output logic       ack_pulse,
  output logic       missed,
  output logic [1:0] snooze_cnt
);

  localparam int unsigned TICK_W  = cnt_width(CLK_HZ);
  localparam int unsigned SEC_MAX = (RING_TIMEOUT_SEC > SNOOZE_SEC) ? RING_TIMEOUT_SEC : SNOOZE_SEC;
  localparam int unsigned SEC_W   = cnt_width(SEC_MAX + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_HZ - 1);
  localparam logic [SEC_W-1:0]  SEC_TOP   = SEC_W'(SEC_MAX);
  localparam logic [SEC_W-1:0]  RING_SEC  = SEC_W'(RING_TIMEOUT_SEC);
  localparam logic [SEC_W-1:0]  SNZ_SEC   = SEC_W'(SNOOZE_SEC);
  // Snooze limit clamped to what the 2-bit counter can show.
  localparam logic [1:0]        MAX_CNT   = (MAX_SNOOZES > 3) ? 2'd3 : 2'(MAX_SNOOZES);

  logic enter_press, down_press;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_enter (
    .clk   (clk_100mhz),
    .rst_n (rst_n),
    .raw   (btn_enter),
    .press (enter_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
    .clk   (clk_100mhz),
    .rst_n (rst_n),
    .raw   (btn_down),
    .press (down_press)
  );

  logic areq_s1_q, areq_s2_q, areq_prev_q;
  logic alarm_start;

  state_t            state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [SEC_W-1:0]  sec_q, sec_d;
  logic [1:0]        snooze_cnt_q, snooze_cnt_d;
  logic              missed_q, missed_d;
  logic              ack_q, ack_d;
  logic              ring_q, ring_d;
  logic              snoozing_q, snoozing_d;

  assign alarm_start = areq_s2_q & ~areq_prev_q;

  // Next-state and event logic; enable dominates, then enter, down, expiry.
  always_comb begin
    state_d      = state_q;
    snooze_cnt_d = snooze_cnt_q;
    missed_d     = missed_q;
    ack_d        = 1'b0;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (alarm_start) begin
            state_d      = RINGING;
            snooze_cnt_d = 2'd0;
            missed_d     = 1'b0;
          end
        end
        RINGING: begin
          if (enter_press) begin
            state_d = DONE;
            ack_d   = 1'b1;
          end else if (down_press && (snooze_cnt_q < MAX_CNT)) begin
            state_d      = SNOOZE;
            snooze_cnt_d = snooze_cnt_q + 2'd1;
          end else if (sec_q == RING_SEC) begin
            state_d  = DONE;
            missed_d = 1'b1;
          end
        end
        SNOOZE: begin
          if (enter_press) begin
            state_d = DONE;
            ack_d   = 1'b1;
          end else if (sec_q == SNZ_SEC) begin
            state_d = RINGING;
          end
        end
        DONE: begin
          if (!areq_s2_q) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Seconds timebase: only runs while ringing or snoozing, restarts on any state change.
  always_comb begin
    tick_d = tick_q;
    sec_d  = sec_q;
    if ((state_d != state_q) || !((state_q == RINGING) || (state_q == SNOOZE))) begin
      tick_d = '0;
      sec_d  = '0;
    end else if (tick_q == TICK_LAST) begin
      tick_d = '0;
      if (sec_q != SEC_TOP) sec_d = sec_q + 1'b1;
    end else begin
      tick_d = tick_q + 1'b1;
    end
  end

  // Outputs are decoded from the next state so they register with it.
  always_comb begin
    ring_d     = (state_d == RINGING);
    snoozing_d = (state_d == SNOOZE);
  end

  // All controller state, synchroniser and output registers.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      areq_s1_q    <= 1'b0;
      areq_s2_q    <= 1'b0;
      areq_prev_q  <= 1'b0;
      state_q      <= IDLE;
      tick_q       <= '0;
      sec_q        <= '0;
      snooze_cnt_q <= 2'd0;
      missed_q     <= 1'b0;
      ack_q        <= 1'b0;
      ring_q       <= 1'b0;
      snoozing_q   <= 1'b0;
    end else begin
      areq_s1_q    <= alarm_req;
      areq_s2_q    <= areq_s1_q;
      areq_prev_q  <= areq_s2_q;
      state_q      <= state_d;
      tick_q       <= tick_d;
      sec_q        <= sec_d;
      snooze_cnt_q <= snooze_cnt_d;
      missed_q     <= missed_d;
      ack_q        <= ack_d;
      ring_q       <= ring_d;
      snoozing_q   <= snoozing_d;
    end
  end

  assign ring       = ring_q;
  assign snoozing   = snoozing_q;
  assign ack_pulse  = ack_q;
  assign missed     = missed_q;
  assign snooze_cnt = snooze_cnt_q;

endmodule

// File: tb/tb_alarm_ack_ctrl.sv
// Directed bench for alarm_ack_ctrl using short test timing.
module tb_alarm_ack_ctrl;
  import alarm_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       alarm_req;
  logic       btn_enter;
  logic       btn_down;
  logic       ring;
  logic       snoozing;
  logic       ack_pulse;
  logic       missed;
  logic [1:0] snooze_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int ack_cnt  = 0;

  alarm_ack_ctrl #(
    .CLK_HZ           (100),
    .DEBOUNCE_CYCLES  (4),
    .SNOOZE_SEC       (2),
    .MAX_SNOOZES      (3),
    .RING_TIMEOUT_SEC (3)
  ) dut (
    .clk_100mhz (clk),
    .rst_n      (rst_n),
    .en         (en),
    .alarm_req  (alarm_req),
    .btn_enter  (btn_enter),
    .btn_down   (btn_down),
    .ring       (ring),
    .snoozing   (snoozing),
    .ack_pulse  (ack_pulse),
    .missed     (missed),
    .snooze_cnt (snooze_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count cycles in which ack_pulse is high.
  always @(negedge clk) if (ack_pulse === 1'b1) ack_cnt = ack_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ring(input string tag, input int budget);
    int n = 0;
    while (ring !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, ring, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; alarm_req = 1'b0; btn_enter = 1'b0; btn_down = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(3);
    chk("rst_ring", ring, 0);
    chk("rst_snoozing", snoozing, 0);
    chk("rst_ack", ack_pulse, 0);
    chk("rst_missed", missed, 0);
    chk("rst_snooze_cnt", snooze_cnt, 0);
    chk("rst_state", dut.state_q, IDLE);

    // Dismiss
    en = 1'b1;
    cyc(2);
    alarm_req = 1'b1;
    cyc(2);
    chk("ring_not_yet", ring, 0);
    cyc(1);
    chk("ring_on", ring, 1);
    ack_cnt = 0;
    btn_enter = 1'b1;
    cyc(10);
    btn_enter = 1'b0;
    chk("dismiss_ack_once", ack_cnt, 1);
    chk("dismiss_ring_off", ring, 0);
    chk("dismiss_cnt", snooze_cnt, 0);
    chk("dismiss_missed", missed, 0);
    chk("dismiss_state", dut.state_q, DONE);
    cyc(8);
    chk("done_no_retrigger", ring, 0);
    alarm_req = 1'b0;
    cyc(4);
    chk("dismiss_idle", dut.state_q, IDLE);

    // Snooze cycle
    alarm_req = 1'b1;
    cyc(4);
    chk("snz_ring_on", ring, 1);
    btn_down = 1'b1;
    cyc(10);
    btn_down = 1'b0;
    chk("snz_snoozing", snoozing, 1);
    chk("snz_ring_off", ring, 0);
    chk("snz_cnt1", snooze_cnt, 1);
    cyc(196);
    chk("snz_still_snoozing", snoozing, 1);
    cyc(2);
    chk("snz_ring_back", ring, 1);
    chk("snz_snoozing_off", snoozing, 0);

    // Snooze limit
    cyc(2);
    btn_down = 1'b1;
    cyc(10);
    btn_down = 1'b0;
    chk("lim_cnt2", snooze_cnt, 2);
    chk("lim_snoozing2", snoozing, 1);
    wait_ring("lim_ring_back2", 250);
    btn_down = 1'b1;
    cyc(10);
    btn_down = 1'b0;
    chk("lim_cnt3", snooze_cnt, 3);
    wait_ring("lim_ring_back3", 250);
    ack_cnt = 0;
    btn_down = 1'b1;
    cyc(10);
    btn_down = 1'b0;
    chk("lim_4th_ring", ring, 1);
    chk("lim_4th_no_snooze", snoozing, 0);
    chk("lim_4th_cnt", snooze_cnt, 3);
    cyc(288);
    chk("lim_before_timeout", ring, 1);
    cyc(4);
    chk("lim_timeout_ring", ring, 0);
    chk("lim_missed", missed, 1);
    chk("lim_no_ack", ack_cnt, 0);
    chk("lim_state_done", dut.state_q, DONE);
    alarm_req = 1'b0;
    cyc(4);
    chk("lim_idle", dut.state_q, IDLE);
    chk("lim_missed_sticky", missed, 1);

    // Bounce rejection
    alarm_req = 1'b1;
    cyc(4);
    chk("bnc_ring_on", ring, 1);
    chk("bnc_missed_clear", missed, 0);
    chk("bnc_cnt_clear", snooze_cnt, 0);
    ack_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      btn_enter = (i % 2 == 0);
      cyc(2);
    end
    btn_enter = 1'b0;
    cyc(10);
    chk("bnc_no_ack", ack_cnt, 0);
    chk("bnc_ring_stays", ring, 1);

    // Enter and down together
    ack_cnt = 0;
    btn_enter = 1'b1;
    btn_down = 1'b1;
    cyc(10);
    btn_enter = 1'b0;
    btn_down = 1'b0;
    chk("pri_ack", ack_cnt, 1);
    chk("pri_cnt", snooze_cnt, 0);
    chk("pri_no_snooze", snoozing, 0);
    chk("pri_ring_off", ring, 0);
    cyc(8);
    alarm_req = 1'b0;
    cyc(4);

    // Enable dropped mid-ringing
    alarm_req = 1'b1;
    cyc(4);
    chk("en_ring_on", ring, 1);
    ack_cnt = 0;
    en = 1'b0;
    cyc(1);
    chk("en_ring_off", ring, 0);
    chk("en_state_idle", dut.state_q, IDLE);
    en = 1'b1;
    cyc(20);
    chk("en_no_retrigger", ring, 0);
    chk("en_no_ack", ack_cnt, 0);
    alarm_req = 1'b0;
    cyc(4);
    alarm_req = 1'b1;
    cyc(4);
    chk("en_fresh_edge_ring", ring, 1);

    // Async reset mid-snooze
    btn_down = 1'b1;
    cyc(10);
    btn_down = 1'b0;
    chk("ar_snoozing", snoozing, 1);
    chk("ar_cnt1", snooze_cnt, 1);
    #2;
    rst_n = 1'b0;
    alarm_req = 1'b0;
    #1;
    chk("ar_snoozing_now", snoozing, 0);
    chk("ar_ring_now", ring, 0);
    chk("ar_cnt_now", snooze_cnt, 0);
    chk("ar_missed_now", missed, 0);
    chk("ar_ack_now", ack_pulse, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(5);
    chk("ar_state_idle", dut.state_q, IDLE);
    chk("ar_ring_idle", ring, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
